// File: rtl/ga_pkg.sv
// Shared GA definitions: controller/mutation state codes, population geometry defaults and the LFSR step.
package ga_pkg;

  localparam int POP_DEF    = 8;
  localparam int GENES_DEF  = 16;
  localparam int GENE_W_DEF = 8;

  typedef enum logic [2:0] {
    CTRL_INITIAL   = 3'b000,
    CTRL_FITNESS   = 3'b001,
    CTRL_SELECT    = 3'b010,
    CTRL_MUTATION  = 3'b011,
    CTRL_FINISHED  = 3'b100
  } ctrl_state_e;

  typedef enum logic [3:0] {
    MUT_IDLE     = 4'b0000,
    MUT_RD       = 4'b0001,
    MUT_WAIT     = 4'b0010,
    MUT_MUTATE   = 4'b0011,
    MUT_WR       = 4'b0100,
    MUT_FINISHED = 4'b1001
  } mut_state_e;

  // Fibonacci taps 16,14,13,11; shift left with feedback into bit 0.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/ga_lfsr16.sv
// 16-bit Fibonacci LFSR; steps once per cycle with advance high, loads seed on reset.
// No backpressure: value is always valid.
module ga_lfsr16
  import ga_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = value_q;
    if (advance) begin
      value_d = lfsr16_next(value_q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q <= seed;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/mutation_fsm.sv
// Copies the elite chromosome over rows 1..POP-1, randomly mutating genes; 4 cycles per gene written.
// The controller gates progress: leaving the mutation phase aborts to IDLE on the same edge.
module mutation_fsm
  import ga_pkg::*;
#(
  parameter int          POP       = POP_DEF,
  parameter int          GENES     = GENES_DEF,
  parameter int          GENE_W    = GENE_W_DEF,
  parameter logic [4:0]  MUT_RATE  = 5'd2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [2:0]        state_controller,
  output logic [3:0]        state_mutationFSM,
  output logic [6:0]        mem_addr,
  input  logic [GENE_W-1:0] mem_rdata,
  output logic [GENE_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [7:0]        mutation_count
);

  localparam int CW = (POP > 1) ? $clog2(POP) : 1;
  localparam int GW = (GENES > 1) ? $clog2(GENES) : 1;

  mut_state_e        state_q, state_d;
  logic [CW-1:0]     chrom_q, chrom_d;
  logic [GW-1:0]     gidx_q, gidx_d;
  logic [GENE_W-1:0] gene_q, gene_d;
  logic [7:0]        mcount_q, mcount_d;

  logic [15:0] lfsr_value;
  logic        lfsr_adv;
  logic        run;
  logic [6:0]  wr_addr;
  logic        lfsr_unused;

  ga_lfsr16 u_lfsr (
    .clock   (CLOCK_50),
    .reset   (reset),
    .advance (lfsr_adv),
    .seed    (LFSR_SEED),
    .value   (lfsr_value)
  );

  // Only the low nibble (decision) and high byte (replacement gene) are consumed.
  assign lfsr_unused = ^lfsr_value[7:4];

  assign run     = (state_controller == CTRL_MUTATION);
  assign wr_addr = 7'(int'(chrom_q) * GENES + int'(gidx_q));

  always_comb begin
    state_d   = state_q;
    chrom_d   = chrom_q;
    gidx_d    = gidx_q;
    gene_d    = gene_q;
    mcount_d  = mcount_q;
    lfsr_adv  = 1'b0;
    mem_addr  = 7'd0;
    mem_wdata = '0;
    mem_we    = 1'b0;

    case (state_q)
      MUT_IDLE: begin
        if (run) begin
          state_d  = MUT_RD;
          chrom_d  = CW'(1);
          gidx_d   = '0;
          mcount_d = 8'd0;
        end
      end

      MUT_RD: begin
        mem_addr = 7'(gidx_q);
        state_d  = run ? MUT_WAIT : MUT_IDLE;
      end

      MUT_WAIT: begin
        gene_d  = mem_rdata;
        state_d = run ? MUT_MUTATE : MUT_IDLE;
      end

      MUT_MUTATE: begin
        lfsr_adv = 1'b1;
        if ({1'b0, lfsr_value[3:0]} < MUT_RATE) begin
          gene_d = GENE_W'(lfsr_value[15:8]);
          if (mcount_q != 8'hFF) begin
            mcount_d = mcount_q + 8'd1;
          end
        end
        state_d = run ? MUT_WR : MUT_IDLE;
      end

      MUT_WR: begin
        mem_addr  = wr_addr;
        mem_wdata = gene_q;
        mem_we    = 1'b1;
        // The strobe above lands on this edge even when aborting.
        if (!run) begin
          state_d = MUT_IDLE;
        end else if (int'(gidx_q) < GENES - 1) begin
          gidx_d  = gidx_q + GW'(1);
          state_d = MUT_RD;
        end else if (int'(chrom_q) < POP - 1) begin
          gidx_d  = '0;
          chrom_d = chrom_q + CW'(1);
          state_d = MUT_RD;
        end else begin
          state_d = MUT_FINISHED;
        end
      end

      MUT_FINISHED: begin
        if (!run) begin
          state_d = MUT_IDLE;
        end
      end

      default: begin
        state_d = MUT_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= MUT_IDLE;
      chrom_q  <= '0;
      gidx_q   <= '0;
      gene_q   <= '0;
      mcount_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      chrom_q  <= chrom_d;
      gidx_q   <= gidx_d;
      gene_q   <= gene_d;
      mcount_q <= mcount_d;
    end
  end

  assign state_mutationFSM = state_q;
  assign mutation_count    = mcount_q;

endmodule

// File: tb/tb_mutation_fsm.sv
// Drives two mutation_fsm instances (MUT_RATE 0 and 16) in lockstep against a per-gene schedule model.
module tb_mutation_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ctrl;

  logic [3:0] st0, st1;
  logic [6:0] addr0, addr1;
  logic [7:0] rdata0, rdata1, wdata0, wdata1;
  logic       we0, we1;
  logic [7:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mutation_fsm #(.MUT_RATE(5'd0)) dut0 (
    .CLOCK_50(clk), .reset(rst_n), .state_controller(ctrl),
    .state_mutationFSM(st0), .mem_addr(addr0), .mem_rdata(rdata0),
    .mem_wdata(wdata0), .mem_we(we0), .mutation_count(cnt0)
  );

  mutation_fsm #(.MUT_RATE(5'd16)) dut1 (
    .CLOCK_50(clk), .reset(rst_n), .state_controller(ctrl),
    .state_mutationFSM(st1), .mem_addr(addr1), .mem_rdata(rdata1),
    .mem_wdata(wdata1), .mem_we(we1), .mutation_count(cnt1)
  );

  // Gene RAMs: row 0 holds 0x00..0x0F, other rows 0xFF so copies are visible.
  logic [7:0] ram0 [128];
  logic [7:0] ram1 [128];
  int wr0 = 0, wr1 = 0, elite_hits = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) begin
        ram0[i] <= (i < 16) ? 8'(i) : 8'hFF;
        ram1[i] <= (i < 16) ? 8'(i) : 8'hFF;
      end
    end else begin
      if (we0) begin ram0[addr0] <= wdata0; wr0 <= wr0 + 1; end
      if (we1) begin ram1[addr1] <= wdata1; wr1 <= wr1 + 1; end
      if ((we0 && addr0 < 7'd16) || (we1 && addr1 < 7'd16)) elite_hits <= elite_hits + 1;
    end
    rdata0 <= ram0[addr0];
    rdata1 <= ram1[addr1];
  end

  // Model: mode 0 idle, 1 running (m_t = cycle index since start edge), 2 finished.
  int          m_mode, m_t;
  logic [15:0] m_lfsr;
  int          m_cnt [2];
  logic [7:0]  m_data [2];
  int          rate [2] = '{0, 16};

  initial begin
    m_mode = 0; m_t = 0; m_lfsr = 16'hACE1;
    m_cnt[0] = 0; m_cnt[1] = 0; m_data[0] = 0; m_data[1] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_t = 0; m_lfsr = 16'hACE1;
        m_cnt[0] = 0; m_cnt[1] = 0; m_data[0] = 0; m_data[1] = 0;
      end else if (m_mode == 0) begin
        if (ctrl == 3'b011) begin
          m_mode = 1; m_t = 1; m_cnt[0] = 0; m_cnt[1] = 0;
        end
      end else if (m_mode == 1) begin
        if ((m_t - 1) % 4 == 2) begin
          for (int i = 0; i < 2; i++) begin
            if (int'(m_lfsr[3:0]) < rate[i]) begin
              m_data[i] = m_lfsr[15:8];
              if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
            end else begin
              m_data[i] = 8'(((m_t - 1) / 4) % 16);
            end
          end
          m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
        end
        if (ctrl != 3'b011) m_mode = 0;
        else if (m_t == 448) m_mode = 2;
        else m_t = m_t + 1;
      end else begin
        if (ctrl != 3'b011) m_mode = 0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [3:0] st, input logic [6:0] a,
                          input logic [7:0] wd, input logic we, input logic [7:0] c);
    int p, k, es, ea, ewd, ewe;
    p = (m_t - 1) % 4; k = (m_t - 1) / 4;
    es = 0; ea = 0; ewd = 0; ewe = 0;
    if (m_mode == 2) begin
      es = 9;
    end else if (m_mode == 1) begin
      es = p + 1;
      if (p == 0) ea = k % 16;
      if (p == 3) begin ea = 16 + k; ewd = m_data[i]; ewe = 1; end
    end
    chk($sformatf("cmp_state%0d", i), st, es);
    chk($sformatf("cmp_addr%0d", i), a, ea);
    chk($sformatf("cmp_wdata%0d", i), wd, ewd);
    chk($sformatf("cmp_we%0d", i), we, ewe);
    chk($sformatf("cmp_count%0d", i), c, m_cnt[i]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_inst(0, st0, addr0, wdata0, we0, cnt0);
      cmp_inst(1, st1, addr1, wdata1, we1, cnt1);
    end
  end

  int snap0, snap1, bad;

  initial begin
    rst_n = 1'b0;
    ctrl  = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_state", st1, 0);
    chk("rst_we", we1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_wdata", wdata1, 0);
    chk("rst_count", cnt1, 0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_hold", st0, 0);

    // Full pass with both rates.
    #2 ctrl = 3'b011;
    for (int e = 1; e <= 449; e++) begin
      @(negedge clk);
      if (e == 4) begin
        chk("first_wr_addr", addr1, 16);
        chk("first_wr_data", wdata1, 8'hAC);
      end
      if (e == 8) begin
        chk("second_wr_addr", addr1, 17);
        chk("second_wr_data", wdata1, 8'h59);
      end
      if (e == 448) chk("last_wr_state", st0, 4);
    end
    chk("finished_at_449", st0, 9);
    chk("rate0_count", cnt0, 0);
    chk("rate16_count", cnt1, 112);
    chk("rate0_writes", wr0, 112);
    chk("rate16_writes", wr1, 112);
    chk("elite_untouched", elite_hits, 0);
    bad = 0;
    for (int r = 0; r < 8; r++)
      for (int g = 0; g < 16; g++)
        if (ram0[r * 16 + g] != 8'(g)) bad++;
    chk("rows_copy_elite", bad, 0);

    repeat (3) @(negedge clk);
    chk("finished_hold", st1, 9);
    #2 ctrl = 3'b001;
    @(negedge clk);
    chk("finished_exit", st1, 0);

    // Restart, then abort during the 5th write.
    snap0 = wr0; snap1 = wr1;
    #2 ctrl = 3'b011;
    @(negedge clk);
    chk("restart_state", st1, 1);
    chk("restart_count_clear", cnt1, 0);
    repeat (19) @(negedge clk);
    chk("fifth_wr_we", we0, 1);
    chk("fifth_wr_addr", addr0, 20);
    #2 ctrl = 3'b001;
    @(negedge clk);
    chk("abort_state", st0, 0);
    chk("abort_we", we1, 0);
    repeat (2) @(negedge clk);
    chk("abort_writes0", wr0 - snap0, 5);
    chk("abort_writes1", wr1 - snap1, 5);
    chk("abort_elite_untouched", elite_hits, 0);

    // Reset in the middle of a write cycle.
    snap1 = wr1;
    #2 ctrl = 3'b011;
    repeat (12) @(negedge clk);
    chk("pre_reset_we", we1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_we_drop0", we0, 0);
    chk("async_we_drop1", we1, 0);
    chk("async_state", st1, 0);
    chk("async_addr", addr1, 0);
    chk("lfsr_reseed", dut1.u_lfsr.value, 16'hACE1);
    repeat (2) @(negedge clk);
    chk("reset_writes", wr1 - snap1, 2);
    #2 ctrl = 3'b000;
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", st1, 0);
    #2 ctrl = 3'b011;
    repeat (4) @(negedge clk);
    chk("reseeded_wr_data", wdata1, 8'hAC);
    chk("reseeded_rate0_data", wdata0, 8'h00);
    chk("reseeded_wr_addr", addr1, 16);
    #2 ctrl = 3'b000;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mutation_fsm.md
MUTATION_FSM -- requirements
Module: mutation_fsm

Interface
REQ-001 Parameters: POP, 8, population size (chromosome 0 is the elite after sort).
REQ-002 Parameters: GENES, 16, genes per chromosome.
REQ-003 Parameters: GENE_W, 8, gene width in bits.
REQ-004 Parameters: MUT_RATE, 5'd2, mutate a gene when lfsr[3:0] < MUT_RATE; legal range 0..16.
REQ-005 Parameters: LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
REQ-006 Port: CLOCK_50, input, 1, sole clock; all logic on its rising edge.
REQ-007 Port: reset, input, 1, asynchronous active-low reset.
REQ-008 Port: state_controller, input, 3, top controller state; 3'b011 = mutation phase.
REQ-009 Port: state_mutationFSM, output, 4, this FSM's state code; the controller watches it.
REQ-010 Port: mem_addr, output, 7, gene RAM word address = chrom*GENES + gene.
REQ-011 Port: mem_rdata, input, GENE_W, RAM read data, valid one cycle after the address is driven.
REQ-012 Port: mem_wdata / mem_we, output, GENE_W / 1, RAM write data and write strobe.
REQ-013 Port: mutation_count, output, 8, number of genes mutated in the current or last pass.

Function
REQ-014 States SHALL be IDLE 4'b0000, RD 4'b0001, WAIT 4'b0010, MUTATE 4'b0011, WR 4'b0100, FINISHED 4'b1001; any other code SHALL return to IDLE.
REQ-015 IDLE -> RD SHALL occur on the edge that samples state_controller==3'b011; at the same edge chrom=1, gene=0, mutation_count=0.
REQ-016 RD SHALL drive mem_addr=gene (elite row) with mem_we=0, then go to WAIT.
REQ-017 WAIT SHALL capture mem_rdata into gene_q, then go to MUTATE.
REQ-018 MUTATE SHALL test lfsr[3:0] < MUT_RATE: if true, gene_q <= lfsr[15:8] and mutation_count is incremented, saturating at 255; the LFSR SHALL advance exactly once in MUTATE and at no other time.
REQ-019 WR SHALL drive mem_addr=chrom*GENES+gene, mem_wdata=gene_q, mem_we=1 for exactly one cycle.
REQ-020 Leaving WR: if gene<GENES-1, gene++ -> RD; else if chrom<POP-1, gene=0 and chrom++ -> RD; else -> FINISHED.
REQ-021 A full pass SHALL write (POP-1)*GENES words in 4 cycles each; with defaults FINISHED is entered 449 edges after the start edge (start edge included).
REQ-022 FINISHED SHALL hold while state_controller==3'b011 and return to IDLE on the first edge where it is not; mutation_count SHALL hold until the next start.
REQ-023 If state_controller leaves 3'b011 in RD/WAIT/MUTATE/WR, the FSM SHALL go to IDLE on that edge; mem_we SHALL be 0 from then on, and any write already strobed stands.
REQ-024 The elite row (chromosome 0) SHALL never be written.
REQ-025 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0.
REQ-026 mem_addr and mem_wdata SHALL be 0 whenever they are not being driven per REQ-016/REQ-019.

Reset
REQ-027 reset low SHALL immediately force: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, mutation_count 0, chrom/gene 0, lfsr LFSR_SEED.
REQ-028 Reset asserted mid-pass SHALL abort with no further writes; after release, the FSM SHALL wait in IDLE for a fresh start.

Structure
REQ-029 Shared package ga_pkg SHALL hold the controller state codes (initial..finished), the mutation state codes, and the POP/GENES/GENE_W defaults.
REQ-030 The LFSR SHALL be a sub-module ga_lfsr16 (ports: clock, reset, advance, seed, value); the FSM and counters stay in mutation_fsm.

Verification
REQ-031 Bench: hold reset low -> all outputs 0 and state 4'b0000; release with state_controller=3'b000 -> remains IDLE.
REQ-032 Bench: MUT_RATE=0, elite row = 0x00..0x0F, state_controller=3'b011 -> 112 writes, every row copies elite, mutation_count=0, FINISHED at edge 449.
REQ-033 Bench: MUT_RATE=16 -> every written gene equals the successive lfsr[15:8] values from seed 16'hACE1, mutation_count=112.
REQ-034 Bench: in FINISHED, set state_controller=3'b001 -> 4'b0000 next edge; set it back to 3'b011 -> new pass starts and mutation_count clears.
REQ-035 Bench: drop state_controller to 3'b001 during the 5th WR -> IDLE next edge, exactly 5 writes total, address 0..15 never written.
REQ-036 Bench: assert reset mid-WR -> mem_we falls without a clock edge; lfsr returns to 16'hACE1.
